program_loader: RTL and testbench

//  Boot-time writer for the processor's instruction memory; the processor core only ever reads it.

---
 rtl/program_loader.sv | 208 ++++++++++++++++++++
 tb/tb_program_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Boot-time writer for the processor instruction memory.
//               Receives a framed byte stream on a valid/ready interface:
//                 0xA5, LEN_LO, LEN_HI, 4*N data bytes (LSB first), CHK
//               where CHK is the XOR of every data byte. Each group of four
//               data bytes is assembled into a little-endian word and written
//               with a one-cycle strobe. The core is held in reset until a
//               frame completes with a matching checksum.
// Ports       : clock             rising-edge clock
//               reset             asynchronous, active-low
//               in_data/in_valid  stream byte and its qualifier
//               in_ready          byte accepted on in_valid & in_ready
//               imem_*            instruction memory write port
//               core_reset        active-low processor reset (1 only in DONE)
//               load_done         last frame loaded with a good checksum
//               load_error        last frame aborted
//               words_written     words written in the current or last frame
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module program_loader #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MAX_WORDS      = 256,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_write_enable,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_write_data,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           words_written
);

  localparam int              TIMER_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     C_MAX_WORDS  = 16'(MAX_WORDS);
  localparam logic [7:0]      C_SOF        = 8'hA5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [2:0]            state_q,    state_d;
  logic [15:0]           len_q,      len_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_q,     word_d;     // lanes 0..2; lane 3 arrives with the strobe
  logic [7:0]            chk_q,      chk_d;
  logic [15:0]           words_q,    words_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [31:0]           wdata_q,    wdata_d;
  logic [TIMER_W-1:0]    timer_q,    timer_d;

  logic        accept;
  logic        timed;
  logic [15:0] len_full;
  logic [15:0] words_inc;

  assign accept    = in_valid & in_ready;
  assign len_full  = {in_data, len_q[7:0]};
  assign words_inc = words_q + 16'd1;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      chk_q      <= '0;
      words_q    <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      chk_q      <= chk_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      timer_q    <= timer_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    chk_d      = chk_q;
    words_d    = words_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    timer_d    = '0;

    timed = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
            (state_q == S_DATA)   || (state_q == S_CHECK);

    // Inactivity timer only runs while a frame is in progress and waiting
    // for a byte; any accepted byte restarts it.
    if (timed && !accept) begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // Start of frame (also re-arms after DONE/ERROR); other bytes are dropped.
        if (accept && (in_data == C_SOF)) begin
          state_d    = S_LEN_LO;
          len_d      = '0;
          byte_idx_d = '0;
          chk_d      = '0;
          words_d    = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          if ((len_full == 16'd0) || (len_full > C_MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d      = chk_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            default: begin
              // Final byte: latch the word and its address so both hold
              // steady through and after the write strobe.
              wdata_d = {in_data, word_q};
              addr_d  = BASE_ADDR + ADDR_WIDTH'({words_q, 2'b00});
              state_d = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        state_d = (words_inc == len_q) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (in_data == chk_q) ? S_DONE : S_ERROR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timed && !accept && (timer_q == C_TIMER_LAST)) begin
      state_d = S_ERROR;
      timer_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready          = (state_q != S_WRITE);
    imem_write_enable = (state_q == S_WRITE);
    core_reset        = (state_q == S_DONE);
    load_done         = (state_q == S_DONE);
    load_error        = (state_q == S_ERROR);
    imem_address      = addr_q;
    imem_write_data   = wdata_q;
    words_written     = words_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Frame senders push
//               the expected {address, data} of every write into a queue;
//               a monitor pops and compares on each write strobe.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_program_loader;

  localparam int AW   = 32;
  localparam int MAXW = 4;
  localparam int TMO  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_write_enable;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_write_data;
  logic          core_reset;
  logic          load_done;
  logic          load_error;
  logic [15:0]   words_written;

  program_loader #(
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (32'h0000_0000),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .imem_write_enable (imem_write_enable),
    .imem_address      (imem_address),
    .imem_write_data   (imem_write_data),
    .core_reset        (core_reset),
    .load_done         (load_done),
    .load_error        (load_error),
    .words_written     (words_written)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_total = 0;
  int          ready_low_cycles = 0;
  logic [63:0] exp_q[$];
  logic [31:0] fw[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the head of the queue.
  always @(negedge clock) begin
    if (reset) begin
      if (imem_write_enable) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                   imem_address, imem_write_data);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("write_addr", imem_address, e[63:32]);
          check("write_data", imem_write_data, e[31:0]);
          check("ready_during_write", {31'b0, in_ready}, 32'd0);
        end
      end
      if (!in_ready) ready_low_cycles++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Present one byte and hold it until it is accepted on a rising edge.
  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_accept: byte 0x%02h in_ready=%b, expected 1 within 20 cycles", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Full frame from fw[0..n-1] with a hand-computed checksum byte.
  task automatic send_frame(input int n, input logic [7:0] chk, input int max_gap);
    logic [15:0] len;
    logic [31:0] w;
    len = 16'(n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({32'(4 * i), fw[i]});
      exp_total++;
    end
    send(8'hA5);
    send(len[7:0]);
    send(len[15:8]);
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      for (int k = 0; k < 4; k++) begin
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        send(w[8*k +: 8]);
      end
    end
    send(chk);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic crst, input logic [15:0] words);
    check({tag, "_load_done"},     {31'b0, load_done},  {31'b0, done});
    check({tag, "_load_error"},    {31'b0, load_error}, {31'b0, err});
    check({tag, "_core_reset"},    {31'b0, core_reset}, {31'b0, crst});
    check({tag, "_words_written"}, {16'b0, words_written}, {16'b0, words});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   {31'b0, in_ready}, 32'd1);
    check({tag, "_write_en"},   {31'b0, imem_write_enable}, 32'd0);
    check({tag, "_address"},    imem_address, 32'h0);
    check({tag, "_write_data"}, imem_write_data, 32'h0);
    check_status(tag, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    check_reset_values("reset");
    @(negedge clock);
    reset = 1'b1;
    idle(2);
    check_reset_values("post_reset");

    // Junk bytes before SOF in IDLE, random gaps between data bytes.
    send(8'h11);
    send(8'h22);
    send(8'h55);
    check_status("junk", 1'b0, 1'b0, 1'b0, 16'd0);
    fw[0] = 32'hCAFE_F00D;
    fw[1] = 32'h0BAD_C0DE;
    send_frame(2, 8'h71, 2);               // CA^FE^F0^0D^0B^AD^C0^DE = 0x71
    check_status("gaps", 1'b1, 1'b0, 1'b1, 16'd2);

    // Two-word frame, good checksum (XOR of the eight data bytes = 0x2A).
    fw[0] = 32'h1234_5678;
    fw[1] = 32'hDEAD_BEEF;
    send_frame(2, 8'h2A, 0);
    check_status("good", 1'b1, 1'b0, 1'b1, 16'd2);
    check("good_hold_addr", imem_address, 32'h4);
    check("good_hold_data", imem_write_data, 32'hDEAD_BEEF);

    // Same frame, wrong checksum: words still written, core stays in reset.
    send_frame(2, 8'h00, 0);
    check_status("badchk", 1'b0, 1'b1, 1'b0, 16'd2);

    // Zero length and MAX_WORDS+1: error straight after LEN_HI.
    send(8'hA5); send(8'h00); send(8'h00);
    idle(2);
    check_status("len0", 1'b0, 1'b1, 1'b0, 16'd0);
    send(8'hA5); send(8'(MAXW + 1)); send(8'h00);
    idle(2);
    check_status("lenmax1", 1'b0, 1'b1, 1'b0, 16'd0);

    // Exactly MAX_WORDS is accepted.
    fw[0] = 32'h1; fw[1] = 32'h2; fw[2] = 32'h3; fw[3] = 32'h4;
    send_frame(MAXW, 8'h04, 0);
    check_status("lenmax", 1'b1, 1'b0, 1'b1, 16'd4);

    // Stall mid-DATA: still waiting at 10 idle cycles, aborted by 20.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h78); send(8'h56);
    check_status("stall_rearm", 1'b0, 1'b0, 1'b0, 16'd0);
    idle(10);
    check("stall_early_error", {31'b0, load_error}, 32'd0);
    idle(10);
    check_status("timeout", 1'b0, 1'b1, 1'b0, 16'd0);
    fw[0] = 32'h1122_3344;
    send_frame(1, 8'h44, 0);
    check_status("after_timeout", 1'b1, 1'b0, 1'b1, 16'd1);

    // Asynchronous reset mid-DATA.
    send(8'hA5); send(8'h02); send(8'h00); send(8'hAA); send(8'hBB);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    idle(2);
    reset = 1'b1;
    idle(1);
    fw[0] = 32'h00C0_FFEE;
    send_frame(1, 8'hD1, 0);               // EE^FF^C0^00 = 0xD1
    check_status("after_reset", 1'b1, 1'b0, 1'b1, 16'd1);

    idle(3);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("ready_low_cycles", 32'(ready_low_cycles), 32'(exp_total));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
